// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// prefix byte codes and bit positions inside the 11-bit ps2_key word.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int unsigned KEY_TGL = 10;
  localparam int unsigned KEY_PRS = 9;
  localparam int unsigned KEY_EXT = 8;
  localparam int unsigned KEY_W   = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus debounce for an asynchronous PS/2 line.
// The filtered level flips only after FILT_LEN consecutive synchronized
// samples at the opposite level.
// Ports:
//   clk_sys  in   system clock
//   reset    in   async active-high reset (level returns to idle high)
//   line_i   in   raw asynchronous line
//   level_o  out  filtered level (registered)
//   fall_o   out  one-cycle pulse in the cycle level_o goes low (registered)
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Run-length count of samples disagreeing with the current filtered level.
  always_comb begin
    lvl_d  = lvl_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        lvl_d  = s2_q;
        fall_d = lvl_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      lvl_q  <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = lvl_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deserializes device-to-host frames, tracks the
// E0 (extended) and F0 (break) prefixes and publishes an 11-bit key word
// whose bit 10 toggles once per completed key event.
// Optional watchdog: define PS2_RX_WATCHDOG_EN to abort a frame that sees
// no filtered clock fall for TIMEOUT_CYC cycles.
// Ports:
//   clk_sys       in   system clock
//   reset         in   async active-high reset
//   ps2_kbd_clk   in   PS/2 clock line (async, idle high)
//   ps2_kbd_data  in   PS/2 data line (async, idle high)
//   ps2_key       out  {toggle, pressed, extended, scan[7:0]}
//   frame_err     out  one-cycle pulse on a bad frame or watchdog abort
//   busy          out  high while a frame is in progress
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ps2_kbd_clk,
  input  logic             ps2_kbd_data,
  output logic [KEY_W-1:0] ps2_key,
  output logic             frame_err,
  output logic             busy
);

  if (FILT_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("ps2_kbd_rx: FILT_LEN must be >= 2 and TIMEOUT_CYC >= 1");
  end

  logic clk_lvl, clk_fall;
  logic d1_q, d2_q;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .line_i  (ps2_kbd_clk),
    .level_o (clk_lvl),
    .fall_o  (clk_fall)
  );

  ps2_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             ext_q, ext_d;
  logic             rel_q, rel_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             fall;

  // clk_lvl is already low whenever clk_fall fires; qualifying keeps both in use.
  assign fall = clk_fall & ~clk_lvl;

`ifdef PS2_RX_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Frame FSM, prefix tracking and output update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    key_d   = key_q;
    err_d   = 1'b0;
    if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!d2_q) begin
            state_d = ST_DATA;
            cnt_d   = 3'd0;
          end
        end
        ST_DATA: begin
          shreg_d = {d2_q, shreg_q[7:1]};
          if (cnt_q == 3'd7) state_d = ST_PARITY;
          else               cnt_d   = cnt_q + 3'd1;
        end
        ST_PARITY: begin
          par_d   = d2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          if ((^{shreg_q, par_q}) && d2_q) begin
            if (shreg_q == PS2_PFX_EXT) begin
              ext_d = 1'b1;
            end else if (shreg_q == PS2_PFX_BRK) begin
              rel_d = 1'b1;
            end else begin
              key_d[KEY_TGL] = ~key_q[KEY_TGL];
              key_d[KEY_PRS] = ~rel_q;
              key_d[KEY_EXT] = ext_q;
              key_d[7:0]     = shreg_q;
              ext_d          = 1'b0;
              rel_d          = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef PS2_RX_WATCHDOG_EN
    // Watchdog: cleared on every fall and in IDLE, aborts the frame at the limit.
    wd_d = wd_q;
    if (fall || state_q == ST_IDLE) begin
      wd_d = '0;
    end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
      wd_d    = '0;
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
      err_d   = 1'b1;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      d1_q    <= 1'b1;
      d2_q    <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      shreg_q <= 8'h00;
      par_q   <= 1'b0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      key_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PS2_RX_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      d1_q    <= ps2_kbd_data;
      d2_q    <= d1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      key_q   <= key_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef PS2_RX_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: a behavioural model of the key word is
// advanced as frames are driven; the monitor pops and compares on every
// ps2_key change or frame_err pulse.
module tb_ps2_kbd_rx;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_kbd_clk  = 1'b1;
  logic        ps2_kbd_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  ps2_kbd_rx dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_kbd_clk  (ps2_kbd_clk),
    .ps2_kbd_data (ps2_kbd_data),
    .ps2_key      (ps2_key),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit          is_err;
    logic [10:0] key;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [10:0] m_key = '0;
  bit          m_ext = 0, m_rel = 0;
  logic [10:0] prev_key = '0;
  bit          err_prev = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  // Drive n bits of a frame LSB first; each bit is a 40-cycle PS/2 clock period.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_kbd_data = bits[i];
      cyc(10);
      ps2_kbd_clk = 1'b0;
      cyc(20);
      ps2_kbd_clk = 1'b1;
      cyc(10);
    end
    ps2_kbd_data = 1'b1;
  endtask

  // Update the model, push the expectation, then drive the frame.
  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic  par;
    exp_t  e;
    par = ~(^b) ^ bad_par;
    if (bad_par) begin
      e.is_err = 1; e.key = m_key; sb.push_back(e);
      m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      m_key = {~m_key[10], ~m_rel, m_ext, b};
      e.is_err = 0; e.key = m_key; sb.push_back(e);
      m_ext = 0; m_rel = 0;
    end
    send_bits({1'b1, par, b, 1'b0}, 11);
    cyc(20);
  endtask

  // Monitor: every ps2_key change or frame_err pulse consumes one expectation.
  always @(negedge clk_sys) begin
    exp_t e;
    if (reset) begin
      prev_key = ps2_key;
      err_prev = 0;
    end else begin
      if (err_prev) chk("err_one_cycle", 32'(frame_err), 32'd0);
      err_prev = frame_err;
      if (frame_err) begin
        if (sb.size() == 0) chk("err_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("err_kind", 32'(e.is_err), 32'd1);
        end
        chk("err_key_held", 32'(ps2_key), 32'(prev_key));
      end else if (ps2_key !== prev_key) begin
        if (sb.size() == 0) chk("key_unexpected", 32'(ps2_key), 32'(prev_key));
        else begin
          e = sb.pop_front();
          chk("key_kind", 32'(e.is_err), 32'd0);
          chk("key", 32'(ps2_key), 32'(e.key));
        end
      end
      prev_key = ps2_key;
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int busy_seen;
    exp_t e;
    cyc(3);
    #1;
    chk("rst_key", 32'(ps2_key), 32'h000);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc(5);

    // Plain make code, then break code, then extended make/break.
    send_byte(8'h1C, 0);
    drain("drain_make");
    chk("model_61c", 32'(m_key), 32'h61C);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h75, 0);
    send_byte(8'hE1, 0);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);

    // Parity error drops the byte and clears a pending prefix.
    send_byte(8'hE0, 0);
    send_byte(8'h1C, 1);
    send_byte(8'h1C, 0);
    drain("drain_parity");

    // Short low glitch on the clock while idle.
    busy_seen = 0;
    ps2_kbd_clk = 1'b0;
    cyc(3);
    ps2_kbd_clk = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (busy) busy_seen++;
    end
    chk("glitch_busy", 32'(busy_seen), 32'd0);

    // Partial frame: start + 3 data bits, then the clock stays high.
    send_bits(11'b000_0000_0110, 4);
    @(negedge clk_sys);
    chk("partial_busy", 32'(busy), 32'd1);
`ifdef PS2_RX_WATCHDOG_EN
    e.is_err = 1; e.key = m_key; sb.push_back(e);
    m_ext = 0; m_rel = 0;
    cyc(50100);
    drain("drain_watchdog");
    @(negedge clk_sys);
    chk("wd_busy", 32'(busy), 32'd0);
    send_bits(11'b000_0000_0110, 4);
`else
    cyc(50100);
    @(negedge clk_sys);
    chk("no_wd_busy", 32'(busy), 32'd1);
`endif

    // Reset mid-frame returns to reset values immediately.
    @(posedge clk_sys);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_key", 32'(ps2_key), 32'h000);
    chk("midrst_err", 32'(frame_err), 32'd0);
    m_key = '0; m_ext = 0; m_rel = 0;
    sb.delete();
    cyc(3);
    reset = 1'b0;
    cyc(5);

    send_byte(8'h1C, 0);
    drain("drain_final");
    chk("final_key", 32'(ps2_key), 32'h61C);
    cyc(50);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
